// File: rtl/dsp_mem_pkg.sv
// Shared definitions for the multi-port DSP read-data memory:
// controller state encoding, pipeline depth limit and a width helper.
package dsp_mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int RD_LAT_MAX = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_rdmem_port.sv
// One read port of the DSP read-data memory: samples the addressed word,
// optionally forwards a same-cycle write, and delays data/valid by RD_LAT.
module dsp_rdmem_port
  import dsp_mem_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 4,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] mem_word,
  input  logic          wr_fire,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] word_sel;
  logic [DW-1:0] s1_data;
  logic          s1_valid;

  // The array still holds the old word during a colliding write, so new data is forwarded here.
  always_comb begin
    word_sel = mem_word;
    if (WR_FIRST != 0 && wr_fire && rd_addr == wr_addr) word_sel = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_req;
      if (rd_req) s1_data <= word_sel;
    end
  end

  generate
    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: rtl/dsp_rdata_mem_mp.sv
// Multi-port read-data memory for the DSP datapath: one write port, NUM_RD
// clocked read ports, and a self-clearing init sequence after every reset.
module dsp_rdata_mem_mp
  import dsp_mem_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 16,
  parameter  int NUM_RD   = 2,
  parameter  int RD_LAT   = 1,
  parameter  int WR_FIRST = 1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_valid,
  output logic                 init_done
);

  mem_state_e    state, state_nxt;
  logic [AW-1:0] init_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic          ready;
  logic          wr_fire;

  assign ready     = (state == ST_READY);
  assign wr_fire   = ready && wr_en;
  assign init_done = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == AW'(DEPTH - 1)) state_nxt = ST_READY;
  end

  // Contents are not reset directly; the INIT sweep zeroes one word per cycle instead.
  always_ff @(posedge clk) begin
    if (!ready) mem[init_cnt] <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      dsp_rdmem_port #(
        .DW       (DW),
        .AW       (AW),
        .RD_LAT   (RD_LAT),
        .WR_FIRST (WR_FIRST)
      ) u_port (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (ready && en),
        .rd_addr  (rd_addr[p*AW +: AW]),
        .mem_word (mem[rd_addr[p*AW +: AW]]),
        .wr_fire  (wr_fire),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data[p*DW +: DW]),
        .rd_valid (rd_valid[p])
      );
    end
  endgenerate

endmodule
